// File: rtl/uart_event_bridge_pkg.sv
// Shared definitions for the UART event bridge.
// Holds the wire-protocol byte values, the response prefix nibbles,
// the parser / TX / command-request enums and a saturating increment helper.
package uart_event_bridge_pkg;

    // Receive-side byte codes
    localparam logic [7:0] HDR_BYTE      = 8'hA5;
    localparam logic [7:0] CMD_ECHO      = 8'hFF;
    localparam logic [7:0] CMD_STATUS    = 8'hFE;
    localparam logic [7:0] CMD_CONFIG    = 8'hFD;
    localparam logic [7:0] CMD_SOFT_RST  = 8'hFC;
    localparam logic [7:0] CMD_ERR_QUERY = 8'hFB;

    // Transmit-side bytes and prefixes
    localparam logic [7:0] ECHO_BYTE     = 8'h55;
    localparam logic [3:0] GEST_PREFIX   = 4'hA;
    localparam logic [3:0] STATUS_PREFIX = 4'hB;

    typedef enum logic [2:0] {
        P_IDLE,
        P_XB,
        P_YB,
        P_POL,
        P_CHK
    } parse_state_t;

    typedef enum logic {
        TX_IDLE,
        TX_SEND
    } tx_state_t;

    typedef enum logic [2:0] {
        CMD_NONE,
        CMD_REQ_ECHO,
        CMD_REQ_STATUS,
        CMD_REQ_CONFIG,
        CMD_REQ_ERRQ
    } cmd_req_t;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/uart_event_bridge_sync_fifo.sv
// Synchronous first-word-fall-through FIFO.
// Ports: clk, rst (sync, active-high); push/din write side; pop/dout read side
// (dout shows the head whenever !empty, zero when empty); full, empty flags.
// A push while full is accepted only when a pop happens in the same cycle.
module uart_event_bridge_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dout    = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/uart_event_bridge.sv
// UART event bridge: parses framed, checksummed event packets from the RX
// byte stream into an event FIFO, decodes single-byte commands, and
// arbitrates multi-byte responses onto the TX byte interface.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   rx_data, rx_valid         received byte + one-cycle strobe
//   tx_data, tx_valid/ready   byte offered to UART TX
//   evt_*, evt_valid/ready    FIFO head toward the accelerator
//   gesture_valid, gesture,
//   gesture_conf              one-cycle gesture result strobe
//   status_in                 accelerator status for status responses
//   soft_rst                  one-cycle pulse on the soft-reset command
//   err_count, ovf_count      saturating error / dropped-event counters
// Handshakes (tx and evt): a transfer happens on a clock edge where valid and
// ready are both high; valid, once raised, holds with stable data until then.
module uart_event_bridge
    import uart_event_bridge_pkg::*;
#(
    parameter int         COORD_W        = 9,
    parameter int         TS_W           = 16,
    parameter int         EVT_FIFO_DEPTH = 8,
    parameter int         NUM_CLASSES    = 4,
    parameter int         TIMEOUT_CYCLES = 2048,
    parameter logic [7:0] CFG_BYTE0      = 8'd20,
    parameter logic [7:0] CFG_BYTE1      = 8'd8,
    localparam int        GW = (NUM_CLASSES > 2) ? $clog2(NUM_CLASSES) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [7:0]         rx_data,
    input  logic               rx_valid,
    output logic [7:0]         tx_data,
    output logic               tx_valid,
    input  logic               tx_ready,
    output logic               evt_valid,
    output logic [COORD_W-1:0] evt_x,
    output logic [COORD_W-1:0] evt_y,
    output logic               evt_pol,
    output logic [TS_W-1:0]    evt_ts,
    input  logic               evt_ready,
    input  logic               gesture_valid,
    input  logic [GW-1:0]      gesture,
    input  logic [3:0]         gesture_conf,
    input  logic [3:0]         status_in,
    output logic               soft_rst,
    output logic [7:0]         err_count,
    output logic [7:0]         ovf_count
);

    localparam int              CB       = (COORD_W + 7) / 8;
    localparam int              EW       = 2 * COORD_W + 1 + TS_W;
    localparam int              TO_W     = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [1:0]      IDX_LAST = 2'(CB - 1);

    parse_state_t        p_state, p_next;
    logic [1:0]          byte_idx;
    logic [COORD_W-1:0]  x_acc, y_acc;
    logic                pol_r;
    logic [7:0]          chk;
    logic [TS_W-1:0]     ts, ts_cap;
    logic [TO_W-1:0]     idle_cnt;
    logic                push_req;
    logic                field_last;
    logic                hdr_hit, stray_hit, soft_hit, chk_ok, chk_bad, timeout_hit;
    cmd_req_t            cmd_sel, cmd_req;

    tx_state_t           tx_state, tx_next;
    logic                load_g, load_c;
    logic                tx_is_cmd, tx_idx, tx_last;
    logic [7:0]          tx_buf [2];

    logic                g_full;
    logic [GW-1:0]       g_class;
    logic [3:0]          g_conf;

    logic                fifo_full, fifo_empty, fifo_pop;
    logic [EW-1:0]       fifo_dout;
    logic                err_inc, ovf_inc, cnt_clr;

    // ---------------- RX parser ----------------
    assign field_last = (byte_idx == IDX_LAST);

    always_ff @(posedge clk) begin
        if (rst) p_state <= P_IDLE;
        else     p_state <= p_next;
    end

    always_comb begin
        p_next      = p_state;
        hdr_hit     = 1'b0;
        stray_hit   = 1'b0;
        soft_hit    = 1'b0;
        chk_ok      = 1'b0;
        chk_bad     = 1'b0;
        timeout_hit = 1'b0;
        cmd_sel     = CMD_NONE;
        if (p_state == P_IDLE) begin
            if (rx_valid) begin
                case (rx_data)
                    HDR_BYTE: begin
                        hdr_hit = 1'b1;
                        p_next  = P_XB;
                    end
                    CMD_ECHO:      cmd_sel  = CMD_REQ_ECHO;
                    CMD_STATUS:    cmd_sel  = CMD_REQ_STATUS;
                    CMD_CONFIG:    cmd_sel  = CMD_REQ_CONFIG;
                    CMD_ERR_QUERY: cmd_sel  = CMD_REQ_ERRQ;
                    CMD_SOFT_RST:  soft_hit = 1'b1;
                    default:       stray_hit = 1'b1;
                endcase
            end
        end else if (!rx_valid) begin
            // idle_cnt holds the idle cycles already seen; this is the last allowed one
            if (idle_cnt == TO_LAST) begin
                timeout_hit = 1'b1;
                p_next      = P_IDLE;
            end
        end else begin
            case (p_state)
                P_XB:  if (field_last) p_next = P_YB;
                P_YB:  if (field_last) p_next = P_POL;
                P_POL: p_next = P_CHK;
                P_CHK: begin
                    p_next  = P_IDLE;
                    chk_ok  = (rx_data == chk);
                    chk_bad = (rx_data != chk);
                end
                default: p_next = P_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ts       <= '0;
            ts_cap   <= '0;
            x_acc    <= '0;
            y_acc    <= '0;
            pol_r    <= 1'b0;
            chk      <= '0;
            byte_idx <= '0;
            idle_cnt <= '0;
            push_req <= 1'b0;
            soft_rst <= 1'b0;
        end else begin
            ts       <= ts + TS_W'(1);
            soft_rst <= soft_hit;
            // FIFO push is registered: the packet fields stay stable in IDLE
            push_req <= chk_ok;
            if (p_state == P_IDLE || rx_valid) idle_cnt <= '0;
            else                               idle_cnt <= idle_cnt + TO_W'(1);
            if (hdr_hit) begin
                ts_cap   <= ts;
                chk      <= '0;
                byte_idx <= '0;
            end
            if (rx_valid) begin
                case (p_state)
                    P_XB: begin
                        // MSB-first shift; bits above COORD_W fall off the top
                        x_acc    <= COORD_W'({x_acc, rx_data});
                        chk      <= chk ^ rx_data;
                        byte_idx <= field_last ? 2'd0 : byte_idx + 2'd1;
                    end
                    P_YB: begin
                        y_acc    <= COORD_W'({y_acc, rx_data});
                        chk      <= chk ^ rx_data;
                        byte_idx <= field_last ? 2'd0 : byte_idx + 2'd1;
                    end
                    P_POL: begin
                        pol_r <= rx_data[0];
                        chk   <= chk ^ rx_data;
                    end
                    default: ;
                endcase
            end
        end
    end

    // ---------------- Event FIFO ----------------
    assign fifo_pop  = evt_valid & evt_ready;
    assign evt_valid = ~fifo_empty;
    assign {evt_x, evt_y, evt_pol, evt_ts} = fifo_dout;

    uart_event_bridge_sync_fifo #(
        .WIDTH (EW),
        .DEPTH (EVT_FIFO_DEPTH)
    ) u_evt_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_req),
        .din   ({x_acc, y_acc, pol_r, ts_cap}),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // ---------------- Error counters ----------------
    assign err_inc = stray_hit | chk_bad | timeout_hit;
    assign ovf_inc = push_req & fifo_full & ~fifo_pop;
    assign cnt_clr = load_c & (cmd_req == CMD_REQ_ERRQ);

    always_ff @(posedge clk) begin
        if (rst || cnt_clr) begin
            err_count <= '0;
            ovf_count <= '0;
        end else begin
            if (err_inc) err_count <= sat_inc(err_count);
            if (ovf_inc) ovf_count <= sat_inc(ovf_count);
        end
    end

    // ---------------- Gesture slot / command request ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            g_full  <= 1'b0;
            g_class <= '0;
            g_conf  <= '0;
            cmd_req <= CMD_NONE;
        end else begin
            // A strobe in the load cycle refills the slot with the newer result
            if (gesture_valid) begin
                g_full  <= 1'b1;
                g_class <= gesture;
                g_conf  <= gesture_conf;
            end else if (load_g) begin
                g_full <= 1'b0;
            end
            if (load_c)
                cmd_req <= CMD_NONE;
            else if (cmd_sel != CMD_NONE && cmd_req == CMD_NONE &&
                     !(tx_state == TX_SEND && tx_is_cmd))
                cmd_req <= cmd_sel;
        end
    end

    // ---------------- TX arbiter ----------------
    always_ff @(posedge clk) begin
        if (rst) tx_state <= TX_IDLE;
        else     tx_state <= tx_next;
    end

    always_comb begin
        tx_next = tx_state;
        load_g  = 1'b0;
        load_c  = 1'b0;
        case (tx_state)
            TX_IDLE: begin
                if (g_full) begin
                    load_g  = 1'b1;
                    tx_next = TX_SEND;
                end else if (cmd_req != CMD_NONE) begin
                    load_c  = 1'b1;
                    tx_next = TX_SEND;
                end
            end
            TX_SEND: if (tx_ready && tx_idx == tx_last) tx_next = TX_IDLE;
            default: tx_next = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_is_cmd <= 1'b0;
            tx_idx    <= 1'b0;
            tx_last   <= 1'b0;
            tx_buf[0] <= '0;
            tx_buf[1] <= '0;
        end else if (load_g) begin
            tx_is_cmd <= 1'b0;
            tx_idx    <= 1'b0;
            tx_last   <= 1'b1;
            tx_buf[0] <= {GEST_PREFIX, 4'(g_class)};
            tx_buf[1] <= {g_conf, 4'h0};
        end else if (load_c) begin
            tx_is_cmd <= 1'b1;
            tx_idx    <= 1'b0;
            case (cmd_req)
                CMD_REQ_ECHO: begin
                    tx_buf[0] <= ECHO_BYTE;
                    tx_last   <= 1'b0;
                end
                CMD_REQ_STATUS: begin
                    tx_buf[0] <= {STATUS_PREFIX, status_in};
                    tx_last   <= 1'b0;
                end
                CMD_REQ_CONFIG: begin
                    tx_buf[0] <= CFG_BYTE0;
                    tx_buf[1] <= CFG_BYTE1;
                    tx_last   <= 1'b1;
                end
                CMD_REQ_ERRQ: begin
                    tx_buf[0] <= err_count;
                    tx_buf[1] <= ovf_count;
                    tx_last   <= 1'b1;
                end
                default: begin
                    tx_buf[0] <= '0;
                    tx_last   <= 1'b0;
                end
            endcase
        end else if (tx_state == TX_SEND && tx_ready && tx_idx != tx_last) begin
            tx_idx <= 1'b1;
        end
    end

    assign tx_valid = (tx_state == TX_SEND);
    assign tx_data  = tx_valid ? tx_buf[tx_idx] : 8'h00;

endmodule

// File: tb/tb_uart_event_bridge.sv
// Testbench for uart_event_bridge: directed packets, commands and gesture
// strobes; expected events and TX bytes are queued at stimulus time and
// checked by independent monitors when the DUT hands them over.
module tb_uart_event_bridge;

    localparam int COORD_W  = 9;
    localparam int TS_W     = 16;
    localparam int DEPTH    = 8;
    localparam int NCLS     = 4;
    localparam int TIMEOUT  = 2048;
    localparam int GW       = 2;
    localparam int EW       = 2 * COORD_W + 1 + TS_W;

    logic               clk;
    logic               rst;
    logic [7:0]         rx_data;
    logic               rx_valid;
    logic [7:0]         tx_data;
    logic               tx_valid;
    logic               tx_ready;
    logic               evt_valid;
    logic [COORD_W-1:0] evt_x;
    logic [COORD_W-1:0] evt_y;
    logic               evt_pol;
    logic [TS_W-1:0]    evt_ts;
    logic               evt_ready;
    logic               gesture_valid;
    logic [GW-1:0]      gesture;
    logic [3:0]         gesture_conf;
    logic [3:0]         status_in;
    logic               soft_rst;
    logic [7:0]         err_count;
    logic [7:0]         ovf_count;

    uart_event_bridge #(
        .COORD_W        (COORD_W),
        .TS_W           (TS_W),
        .EVT_FIFO_DEPTH (DEPTH),
        .NUM_CLASSES    (NCLS),
        .TIMEOUT_CYCLES (TIMEOUT),
        .CFG_BYTE0      (8'd20),
        .CFG_BYTE1      (8'd8)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .rx_data       (rx_data),
        .rx_valid      (rx_valid),
        .tx_data       (tx_data),
        .tx_valid      (tx_valid),
        .tx_ready      (tx_ready),
        .evt_valid     (evt_valid),
        .evt_x         (evt_x),
        .evt_y         (evt_y),
        .evt_pol       (evt_pol),
        .evt_ts        (evt_ts),
        .evt_ready     (evt_ready),
        .gesture_valid (gesture_valid),
        .gesture       (gesture),
        .gesture_conf  (gesture_conf),
        .status_in     (status_in),
        .soft_rst      (soft_rst),
        .err_count     (err_count),
        .ovf_count     (ovf_count)
    );

    // ---------------- clock / reset / reference cycle count ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference timestamp: cycles since reset release, wrapping at 2^TS_W
    logic [TS_W-1:0] cyc;
    always @(posedge clk) begin
        if (rst) cyc <= '0;
        else     cyc <= cyc + TS_W'(1);
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    // ---------------- scoreboard ----------------
    logic [EW-1:0] evt_exp_q[$];
    logic [7:0]    tx_exp_q[$];
    logic [EW-1:0] evt_e;
    logic [7:0]    tx_e;
    int            n_tests = 0;
    int            n_fail  = 0;
    int            soft_cnt = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    always @(negedge clk) begin
        #1;
        if (!rst && evt_valid && evt_ready) begin
            n_tests++;
            if (evt_exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL evt_extra: got x=%0d y=%0d pol=%0d ts=%0d expected none",
                         evt_x, evt_y, evt_pol, evt_ts);
            end else begin
                evt_e = evt_exp_q.pop_front();
                if ({evt_x, evt_y, evt_pol, evt_ts} !== evt_e) begin
                    n_fail++;
                    $display("FAIL evt_data: got x=%0d y=%0d pol=%0d ts=%0d expected x=%0d y=%0d pol=%0d ts=%0d",
                             evt_x, evt_y, evt_pol, evt_ts,
                             evt_e[EW-1 -: COORD_W], evt_e[TS_W+COORD_W -: COORD_W],
                             evt_e[TS_W], evt_e[TS_W-1:0]);
                end
            end
        end
    end

    always @(negedge clk) begin
        #1;
        if (!rst && tx_valid && tx_ready) begin
            n_tests++;
            if (tx_exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL tx_extra: got %02h expected none", tx_data);
            end else begin
                tx_e = tx_exp_q.pop_front();
                if (tx_data !== tx_e) begin
                    n_fail++;
                    $display("FAIL tx_byte: got %02h expected %02h", tx_data, tx_e);
                end
            end
        end
    end

    always @(negedge clk) begin
        #1;
        if (!rst && soft_rst) soft_cnt++;
    end

    // ---------------- driver tasks ----------------
    task automatic send_byte(input logic [7:0] b, input int gap);
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    // Sends A5, X (2 bytes MSB first), Y (2 bytes), POL, CHK; queues the
    // expected event if the checksum is good and the FIFO model has room.
    task automatic send_packet(input logic [15:0] x16, input logic [15:0] y16,
                               input logic [7:0] polb, input bit corrupt, input int gap);
        logic [7:0]      pl [5];
        logic [7:0]      c;
        logic [TS_W-1:0] ts_hdr;
        pl[0] = x16[15:8];
        pl[1] = x16[7:0];
        pl[2] = y16[15:8];
        pl[3] = y16[7:0];
        pl[4] = polb;
        c = 8'h00;
        for (int i = 0; i < 5; i++) c = c ^ pl[i];
        @(negedge clk);
        ts_hdr   = cyc;
        rx_data  = 8'hA5;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        repeat (gap) @(negedge clk);
        for (int i = 0; i < 5; i++) send_byte(pl[i], 0);
        send_byte(corrupt ? ((c == 8'h00) ? 8'h01 : 8'h00) : c, 0);
        if (!corrupt && evt_exp_q.size() < DEPTH)
            evt_exp_q.push_back({x16[COORD_W-1:0], y16[COORD_W-1:0], polb[0], ts_hdr});
    endtask

    task automatic pulse_gesture(input logic [GW-1:0] g, input logic [3:0] conf);
        @(negedge clk);
        gesture       = g;
        gesture_conf  = conf;
        gesture_valid = 1'b1;
        @(negedge clk);
        gesture_valid = 1'b0;
    endtask

    task automatic wait_tx_done(input string name);
        int n;
        n = 0;
        while ((tx_exp_q.size() != 0 || tx_valid) && n < 500) begin
            @(negedge clk);
            n++;
        end
        check(name, 64'(tx_exp_q.size()), 64'd0);
    endtask

    task automatic wait_evt_done(input string name);
        int n;
        n = 0;
        while ((evt_exp_q.size() != 0 || evt_valid) && n < 500) begin
            @(negedge clk);
            n++;
        end
        check(name, 64'(evt_exp_q.size()), 64'd0);
    endtask

    task automatic err_query(input logic [7:0] e, input logic [7:0] o, input string name);
        send_byte(8'hFB, 0);
        tx_exp_q.push_back(e);
        tx_exp_q.push_back(o);
        wait_tx_done(name);
        repeat (2) @(negedge clk);
        check({name, "_err_clr"}, 64'(err_count), 64'd0);
        check({name, "_ovf_clr"}, 64'(ovf_count), 64'd0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        rst           = 1'b1;
        rx_data       = 8'h00;
        rx_valid      = 1'b0;
        tx_ready      = 1'b1;
        evt_ready     = 1'b1;
        gesture_valid = 1'b0;
        gesture       = '0;
        gesture_conf  = '0;
        status_in     = 4'h6;
        repeat (4) @(negedge clk);
        check("rst_tx_valid", 64'(tx_valid), 64'd0);
        check("rst_tx_data", 64'(tx_data), 64'd0);
        check("rst_evt_valid", 64'(evt_valid), 64'd0);
        check("rst_evt_fields", 64'({evt_x, evt_y, evt_pol, evt_ts}), 64'd0);
        check("rst_err", 64'(err_count), 64'd0);
        check("rst_ovf", 64'(ovf_count), 64'd0);
        check("rst_soft", 64'(soft_rst), 64'd0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // Basic packet x=100 y=300 pol=1
        send_packet(16'h0064, 16'h012C, 8'h01, 1'b0, 0);
        wait_evt_done("pkt_basic_drain");
        check("pkt_basic_err", 64'(err_count), 64'd0);
        check("pkt_basic_ovf", 64'(ovf_count), 64'd0);

        // Bad checksum, then a packet exercising ignored upper bits and pol bit 0
        send_packet(16'h0064, 16'h012C, 8'h01, 1'b1, 0);
        repeat (3) @(negedge clk);
        check("badchk_err", 64'(err_count), 64'd1);
        check("badchk_no_evt", 64'(evt_valid), 64'd0);
        send_packet(16'hFE05, 16'h01FF, 8'hFE, 1'b0, 0);
        wait_evt_done("upper_bits_drain");
        err_query(8'h01, 8'h00, "errq_badchk");

        // Overflow: 10 packets into a depth-8 FIFO with the consumer stalled
        evt_ready = 1'b0;
        for (int i = 0; i < 10; i++)
            send_packet(16'(i * 37), 16'(500 - i), 8'(i), 1'b0, 0);
        repeat (3) @(negedge clk);
        check("ovf_count", 64'(ovf_count), 64'd2);
        check("ovf_err", 64'(err_count), 64'd0);
        check("ovf_held", 64'(evt_valid), 64'd1);
        err_query(8'h00, 8'h02, "errq_ovf");
        evt_ready = 1'b1;
        wait_evt_done("ovf_drain");

        // Timeout mid-packet, then recovery; then a long but legal gap
        send_byte(8'hA5, 0);
        send_byte(8'h00, 0);
        send_byte(8'h64, 0);
        repeat (TIMEOUT + 5) @(negedge clk);
        check("timeout_err", 64'(err_count), 64'd1);
        check("timeout_no_evt", 64'(evt_valid), 64'd0);
        send_packet(16'h0123, 16'h0045, 8'h00, 1'b0, 0);
        wait_evt_done("timeout_recover_drain");
        send_packet(16'h0007, 16'h0100, 8'h01, 1'b0, TIMEOUT - 10);
        wait_evt_done("long_gap_drain");
        check("long_gap_err", 64'(err_count), 64'd1);
        err_query(8'h01, 8'h00, "errq_timeout");

        // Gesture result plus echo, with TX stalled for 50 cycles
        tx_ready = 1'b0;
        pulse_gesture(2'd2, 4'd9);
        tx_exp_q.push_back(8'hA2);
        tx_exp_q.push_back(8'h90);
        send_byte(8'hFF, 0);
        tx_exp_q.push_back(8'h55);
        repeat (50) @(negedge clk);
        check("gest_hold_valid", 64'(tx_valid), 64'd1);
        check("gest_hold_data", 64'(tx_data), 64'hA2);
        tx_ready = 1'b1;
        wait_tx_done("gest_echo_drain");

        // Slot overwrite: the newest pending gesture wins
        tx_ready = 1'b0;
        pulse_gesture(2'd1, 4'd3);
        tx_exp_q.push_back(8'hA1);
        tx_exp_q.push_back(8'h30);
        repeat (3) @(negedge clk);
        pulse_gesture(2'd3, 4'd5);
        pulse_gesture(2'd0, 4'hF);
        tx_exp_q.push_back(8'hA0);
        tx_exp_q.push_back(8'hF0);
        repeat (5) @(negedge clk);
        tx_ready = 1'b1;
        wait_tx_done("gest_overwrite_drain");

        // Status and config responses
        send_byte(8'hFE, 0);
        tx_exp_q.push_back(8'hB6);
        wait_tx_done("status_drain");
        send_byte(8'hFD, 0);
        tx_exp_q.push_back(8'h14);
        tx_exp_q.push_back(8'h08);
        wait_tx_done("config_drain");

        // Commands arriving while one is in flight are dropped
        tx_ready = 1'b0;
        send_byte(8'hFF, 0);
        tx_exp_q.push_back(8'h55);
        send_byte(8'hFF, 0);
        send_byte(8'hFE, 0);
        repeat (5) @(negedge clk);
        tx_ready = 1'b1;
        wait_tx_done("cmd_drop_drain");
        repeat (10) @(negedge clk);
        check("cmd_drop_idle", 64'(tx_valid), 64'd0);

        // Stray byte counts as an error; query reads and clears it
        send_byte(8'h10, 2);
        check("stray_err", 64'(err_count), 64'd1);
        err_query(8'h01, 8'h00, "errq_stray");

        // Soft reset pulse: exactly one cycle, no TX side effect
        soft_cnt = 0;
        send_byte(8'hFC, 5);
        check("soft_rst_pulse", 64'(soft_cnt), 64'd1);
        check("soft_rst_no_tx", 64'(tx_valid), 64'd0);

        repeat (5) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
